// File: rtl/dmac_pkg.sv
// dmac_pkg: shared encodings and register map for the multi-channel DMAC slave.
package dmac_pkg;
    typedef enum logic [1:0] {
        ST_WAIT  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_DONE  = 2'b10,
        ST_FAULT = 2'b11
    } status_e;

    typedef enum logic {PS_IDLE, PS_PEND} push_e;

    localparam logic [3:0] OFF_START  = 4'd0;
    localparam logic [3:0] OFF_INT    = 4'd1;
    localparam logic [3:0] OFF_IEN    = 4'd2;
    localparam logic [3:0] OFF_SRC    = 4'd3;
    localparam logic [3:0] OFF_DST    = 4'd4;
    localparam logic [3:0] OFF_SIZE   = 4'd5;
    localparam logic [3:0] OFF_PUSH   = 4'd6;
    localparam logic [3:0] OFF_MODE   = 4'd7;
    localparam logic [3:0] OFF_STATUS = 4'd8;
    localparam logic [3:0] GLOBAL_CH  = 4'hF;
endpackage

// File: rtl/dmac_channel.sv
// dmac_channel: one channel's registers, run FSM, descriptor push FSM and interrupt bits.
module dmac_channel
    import dmac_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                we_i,
    input  logic [3:0]          off_i,
    input  logic [DATA_W-1:0]   din_i,
    input  logic                m_end_i,
    input  logic                fifo_empty_i,
    input  logic                fifo_full_i,
    input  logic                wr_ack_i,
    input  logic                wr_err_i,
    output logic                m_begin_o,
    output logic [1:0]          m_mode_o,
    output logic                push_o,
    output logic [3*DATA_W-1:0] push_data_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                irq_o
);
    logic                start_q, start_d, push_q, push_d;
    logic [1:0]          int_q, int_d, ien_q, ien_d, mode_q, mode_d;
    logic [DATA_W-1:0]   src_q, src_d, dst_q, dst_d, size_q, size_d;
    logic [3*DATA_W-1:0] pdata_q, pdata_d;
    status_e             status_q, status_d;
    push_e               pst_q, pst_d;
    logic                start_go, push_go, done_set, fault_set;
    logic [1:0]          w1c;

    function automatic logic hit(input logic [3:0] o);
        return we_i && off_i == o;
    endfunction

    assign start_go  = hit(OFF_START) && din_i[0] && status_q != ST_EXEC;
    assign push_go   = hit(OFF_PUSH) && din_i[0] && pst_q == PS_IDLE;
    assign done_set  = m_end_i && status_q == ST_EXEC;
    assign fault_set = (start_go && fifo_empty_i) || (push_go && fifo_full_i) || (pst_q == PS_PEND && wr_err_i);
    assign w1c       = hit(OFF_INT) ? din_i[1:0] : 2'b00;

    always_comb begin
        start_d  = hit(OFF_START) ? din_i[0] : 1'b0;
        ien_d    = hit(OFF_IEN) ? din_i[1:0] : ien_q;
        mode_d   = hit(OFF_MODE) ? din_i[1:0] : mode_q;
        src_d    = hit(OFF_SRC) ? din_i : src_q;
        dst_d    = hit(OFF_DST) ? din_i : dst_q;
        size_d   = hit(OFF_SIZE) ? din_i : size_q;
        // hardware set takes priority over a same-cycle W1C clear
        int_d    = (int_q & ~w1c) | {fault_set, done_set};
        push_d   = push_go && !fifo_full_i;
        pdata_d  = push_d ? {size_q, dst_q, src_q} : pdata_q;
        pst_d    = (pst_q == PS_IDLE) ? (push_d ? PS_PEND : PS_IDLE)
                                      : ((wr_ack_i || wr_err_i) ? PS_IDLE : PS_PEND);
        status_d = (w1c[1] && status_q == ST_FAULT) ? ST_WAIT : status_q;
        if (start_go) status_d = fifo_empty_i ? ST_FAULT : ST_EXEC;
        if (done_set) status_d = ST_DONE;
        if (fault_set) status_d = ST_FAULT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q  <= 1'b0;
            int_q    <= '0;
            ien_q    <= '0;
            mode_q   <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            size_q   <= '0;
            push_q   <= 1'b0;
            pdata_q  <= '0;
            pst_q    <= PS_IDLE;
            status_q <= ST_WAIT;
        end else begin
            start_q  <= start_d;
            int_q    <= int_d;
            ien_q    <= ien_d;
            mode_q   <= mode_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            size_q   <= size_d;
            push_q   <= push_d;
            pdata_q  <= pdata_d;
            pst_q    <= pst_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        case (off_i)
            OFF_START:  rdata_o = DATA_W'(start_q);
            OFF_INT:    rdata_o = DATA_W'(int_q);
            OFF_IEN:    rdata_o = DATA_W'(ien_q);
            OFF_SRC:    rdata_o = src_q;
            OFF_DST:    rdata_o = dst_q;
            OFF_SIZE:   rdata_o = size_q;
            OFF_PUSH:   rdata_o = DATA_W'(pst_q == PS_PEND);
            OFF_MODE:   rdata_o = DATA_W'(mode_q);
            OFF_STATUS: rdata_o = DATA_W'(status_q);
            default:    rdata_o = '0;
        endcase
    end

    assign m_begin_o   = status_q == ST_EXEC;
    assign m_mode_o    = mode_q;
    assign push_o      = push_q;
    assign push_data_o = pdata_q;
    assign irq_o       = |(int_q & ien_q);
endmodule

// File: rtl/dmac_slave_mc.sv
// dmac_slave_mc: CPU register slave for N_CH DMA channels with address decode,
// registered read mux and aggregated interrupt.
module dmac_slave_mc
    import dmac_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int N_CH   = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       s_sel,
    input  logic                       s_wr,
    input  logic [ADDR_W-1:0]          s_address,
    input  logic [DATA_W-1:0]          s_din,
    output logic [DATA_W-1:0]          s_dout,
    output logic                       s_interrupt,
    output logic [N_CH-1:0]            m_begin,
    output logic [2*N_CH-1:0]          m_mode,
    input  logic [N_CH-1:0]            m_end,
    input  logic [N_CH-1:0]            fifo_empty,
    input  logic [N_CH-1:0]            fifo_full,
    output logic [N_CH-1:0]            push,
    output logic [3*DATA_W*N_CH-1:0]   push_data,
    input  logic [N_CH-1:0]            wr_ack,
    input  logic [N_CH-1:0]            wr_err
);
    logic [3:0]        ch, off;
    logic [DATA_W-1:0] rdata [N_CH];
    logic [N_CH-1:0]   irq;
    logic [DATA_W-1:0] rd, dout_q, dout_d;
    logic              irq_q;
    logic              unused_addr;

    assign ch  = s_address[7:4];
    assign off = s_address[3:0];
    assign unused_addr = ^s_address[ADDR_W-1:8];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        dmac_channel #(.DATA_W(DATA_W)) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .we_i         (s_sel && s_wr && ch == 4'(c)),
            .off_i        (off),
            .din_i        (s_din),
            .m_end_i      (m_end[c]),
            .fifo_empty_i (fifo_empty[c]),
            .fifo_full_i  (fifo_full[c]),
            .wr_ack_i     (wr_ack[c]),
            .wr_err_i     (wr_err[c]),
            .m_begin_o    (m_begin[c]),
            .m_mode_o     (m_mode[2*c +: 2]),
            .push_o       (push[c]),
            .push_data_o  (push_data[3*DATA_W*c +: 3*DATA_W]),
            .rdata_o      (rdata[c]),
            .irq_o        (irq[c])
        );
    end

    always_comb begin
        rd = (ch == GLOBAL_CH && off == 4'd0) ? DATA_W'(irq) : '0;
        for (int c = 0; c < N_CH; c++) if (ch == 4'(c)) rd = rdata[c];
        dout_d = (s_sel && !s_wr) ? rd : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            irq_q  <= |irq;
        end
    end

    assign s_dout      = dout_q;
    assign s_interrupt = irq_q;
endmodule

// File: tb/tb_dmac_slave_mc.sv
// tb_dmac_slave_mc: directed bench with a read-expectation scoreboard for dmac_slave_mc.
module tb_dmac_slave_mc;
    localparam int DW = 32;
    localparam int NC = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              s_sel = 1'b0, s_wr = 1'b0;
    logic [15:0]       s_address = '0;
    logic [DW-1:0]     s_din = '0;
    logic [DW-1:0]     s_dout;
    logic              s_interrupt;
    logic [NC-1:0]     m_begin, m_end = '0, fifo_empty = '0, fifo_full = '0;
    logic [NC-1:0]     push, wr_ack = '0, wr_err = '0;
    logic [2*NC-1:0]   m_mode;
    logic [3*DW*NC-1:0] push_data;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0]   exp_q [$];
    string           tag_q [$];
    logic [3*DW-1:0] pd_q [$];
    logic [3*DW-1:0] pd_exp;

    always #5 clk = ~clk;

    dmac_slave_mc #(.DATA_W(DW), .ADDR_W(16), .N_CH(NC)) dut (
        .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr),
        .s_address(s_address), .s_din(s_din), .s_dout(s_dout),
        .s_interrupt(s_interrupt), .m_begin(m_begin), .m_mode(m_mode),
        .m_end(m_end), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .push(push), .push_data(push_data), .wr_ack(wr_ack), .wr_err(wr_err)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        s_sel = 1'b1; s_wr = 1'b1; s_address = a; s_din = d;
        @(negedge clk);
        s_sel = 1'b0; s_wr = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [DW-1:0] e, input string tag);
        @(negedge clk);
        s_sel = 1'b1; s_wr = 1'b0; s_address = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        s_sel = 1'b0;
        chk(tag_q.pop_front(), s_dout, exp_q.pop_front());
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_dout", s_dout, 0);
        chk("rst_irq", s_interrupt, 0);
        chk("rst_begin", m_begin, 0);
        chk("rst_push", push, 0);
        chk("rst_pdata", push_data, 0);
        reset_n = 1'b1;
        for (int r = 0; r <= 8; r++) rd(16'(r), 0, $sformatf("rst_reg%0d", r));
        wr(16'h0003, 32'hABCD);
        rd(16'h0003, 32'hABCD, "src0_rd");
        chk("dout_idle", s_dout, 32'hABCD);
        @(negedge clk);
        chk("dout_cleared", s_dout, 0);
        rd(16'h00F0, 0, "glob_rst");

        wr(16'h0013, 32'h100);
        wr(16'h0014, 32'h200);
        wr(16'h0015, 32'h10);
        pd_q.push_back({32'h10, 32'h200, 32'h100});
        wr(16'h0016, 1);
        pd_exp = pd_q.pop_front();
        chk("push1_hi", push, 2'b10);
        chk("push1_data", push_data[3*DW +: 3*DW], pd_exp);
        wr(16'h0013, 32'h999);
        chk("push1_lo", push, 2'b00);
        chk("push1_hold", push_data[3*DW +: 3*DW], pd_exp);
        rd(16'h0016, 1, "push1_pend");
        wr(16'h0016, 1);
        chk("push1_ignored", push, 2'b00);
        @(negedge clk); wr_ack = 2'b10;
        @(negedge clk); wr_ack = 2'b00;
        rd(16'h0016, 0, "push1_idle");

        wr(16'h0007, 3);
        chk("mode0", m_mode[1:0], 2'b11);
        wr(16'h0002, 1);
        wr(16'h0000, 1);
        chk("start0_begin", m_begin[0], 1);
        rd(16'h0008, 1, "start0_exec");
        rd(16'h0000, 0, "start0_selfclr");
        @(negedge clk); m_end = 2'b01;
        @(negedge clk); m_end = 2'b00;
        chk("end0_begin", m_begin[0], 0);
        rd(16'h0008, 2, "end0_done");
        chk("end0_irq", s_interrupt, 1);
        rd(16'h0001, 1, "end0_int");
        rd(16'h00F0, 1, "glob_pend");
        wr(16'h0001, 1);
        @(negedge clk);
        chk("w1c_irq", s_interrupt, 0);

        fifo_empty = 2'b01;
        wr(16'h0000, 1);
        chk("fault_begin", m_begin[0], 0);
        rd(16'h0008, 3, "fault_status");
        rd(16'h0001, 2, "fault_int");
        chk("fault_masked_irq", s_interrupt, 0);
        wr(16'h0001, 2);
        rd(16'h0008, 0, "fault_clr_status");
        rd(16'h0001, 0, "fault_clr_int");
        fifo_empty = 2'b00;

        wr(16'h0000, 1);
        wr(16'h0010, 1);
        chk("both_exec", m_begin, 2'b11);
        @(negedge clk);
        s_sel = 1'b1; s_wr = 1'b1; s_address = 16'h0001; s_din = 1; m_end = 2'b01;
        @(negedge clk);
        s_sel = 1'b0; s_wr = 1'b0; m_end = 2'b00;
        rd(16'h0001, 1, "set_beats_clr");
        wr(16'h0000, 1);
        chk("restart0", m_begin, 2'b11);
        @(negedge clk); m_end = 2'b11;
        @(negedge clk); m_end = 2'b00;
        chk("both_end_begin", m_begin, 2'b00);
        rd(16'h0008, 2, "both_done0");
        rd(16'h0018, 2, "both_done1");
        rd(16'h0011, 1, "both_int1");

        wr(16'h0053, 32'h1234);
        rd(16'h0053, 0, "ch5_ignored");
        rd(16'h0003, 32'hABCD, "ch5_no_alias0");

        wr(16'h0000, 1);
        pd_q.push_back({32'h10, 32'h200, 32'h999});
        wr(16'h0016, 1);
        pd_exp = pd_q.pop_front();
        chk("pre_rst_begin", m_begin[0], 1);
        chk("pre_rst_push", push, 2'b10);
        chk("pre_rst_data", push_data[3*DW +: 3*DW], pd_exp);
        chk("pre_rst_irq", s_interrupt, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_begin", m_begin, 0);
        chk("arst_push", push, 0);
        chk("arst_irq", s_interrupt, 0);
        chk("arst_pdata", push_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(16'h0016, 0, "post_rst_push");
        rd(16'h0008, 0, "post_rst_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmac_slave_mc.md
Name: dmac_slave_mc

Overview:
Multi-channel, parametrised successor to the single-channel DMAC slave register block.
- Provides the CPU-side register file for N_CH independent DMA channels.
- Pushes per-channel descriptors (source address, destination address, size) into per-channel descriptor FIFOs using a push/ack handshake.
- Sequences each channel's master with a begin/end handshake.
- Aggregates per-channel done/fault interrupts into one s_interrupt line.

Parameters:
- DATA_W, 32, register and descriptor word width.
- ADDR_W, 16, slave address width; only bits [7:0] are decoded.
- N_CH, 2, number of channels (1..15).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- s_sel  in  1  slave select
- s_wr  in  1  1=write, 0=read (valid when s_sel=1)
- s_address  in  ADDR_W  [7:4]=channel (0xF=global), [3:0]=register
- s_din  in  DATA_W  write data
- s_dout  out  DATA_W  registered read data
- s_interrupt  out  1  aggregated interrupt
- m_begin  out  N_CH  per-channel start level to master
- m_mode  out  2*N_CH  OPERATION_MODE[1:0] per channel
- m_end  in  N_CH  per-channel completion pulse from master
- fifo_empty  in  N_CH  descriptor FIFO empty
- fifo_full  in  N_CH  descriptor FIFO full
- push  out  N_CH  one-cycle descriptor push strobe
- push_data  out  3*DATA_W*N_CH  per channel {DATA_SIZE, DEST, SRC}; channel c occupies slice c
- wr_ack  in  N_CH  FIFO accepted descriptor
- wr_err  in  N_CH  FIFO rejected descriptor

Behaviour:
- Reset is asynchronous, active-low on reset_n, single clock clk.
- All registers reset to 0 and every channel is in Waiting.
- Outputs at reset: s_dout=0, s_interrupt=0, m_begin=0, push=0, push_data=0.
- Per-channel register offsets:
  - 0 OPERATION_START
  - 1 INTERRUPT: W1C; bit0=done, bit1=fault
  - 2 INTERRUPT_ENABLE: bits[1:0]
  - 3 SOURCE_ADDRESS
  - 4 DESTINATION_ADDRESS
  - 5 DATA_SIZE
  - 6 DESCRIPTOR_PUSH: reads bit0 = push pending
  - 7 OPERATION_MODE
  - 8 DMA_STATUS: read-only; [1:0] = Waiting 00 / Executing 01 / Done 10 / Fault 11
- Global register 0xF0: read-only; bit c = channel c interrupt pending (masked).
- Writes:
  - s_sel=1, s_wr=1 updates the register at the next edge.
  - Writes to read-only registers, unused offsets, or channel >= N_CH are ignored.
- Reads:
  - s_sel=1, s_wr=0: s_dout valid one cycle after the request.
  - Unmapped addresses return 0.
  - s_sel=0: s_dout=0 on the next cycle.
- Channel FSM (Waiting/Done/Fault -> Executing -> Done):
  - Writing OPERATION_START bit0=1 when not Executing:
    - fifo_empty=1 -> Fault, INTERRUPT[1] set, m_begin stays 0.
    - Otherwise m_begin=1 from the next cycle and status=Executing.
  - OPERATION_START bit0 self-clears one cycle after the write.
  - Start writes while Executing are ignored.
  - m_end=1 while Executing: m_begin=0, status=Done and INTERRUPT[0]=1, all at the next edge.
  - m_end in any other state is ignored.
- Push FSM (Idle/Pending):
  - A DESCRIPTOR_PUSH bit0=1 write in Idle:
    - fifo_full=0 -> push=1 for exactly one cycle with push_data capturing the current SRC/DEST/SIZE; go to Pending.
    - fifo_full=1 -> no push, Fault, INTERRUPT[1] set.
  - In Pending:
    - wr_ack -> Idle.
    - wr_err -> Idle plus Fault, INTERRUPT[1] set.
  - Push writes while Pending are ignored.
  - SRC/DEST/SIZE writes during Pending do not alter the captured push_data.
- Interrupts:
  - W1C on INTERRUPT clears the written bits.
  - If a hardware set and a W1C clear of the same bit happen in the same cycle, the set wins.
  - Writing 1 to INTERRUPT bit1 also returns status Fault -> Waiting.
  - s_interrupt (registered) = OR over channels of |(INTERRUPT[1:0] & INTERRUPT_ENABLE[1:0]).
- Independence and reset:
  - Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.
  - Reset mid-operation aborts everything: m_begin and push drop immediately (asynchronously).

Decomposition:
- Package dmac_pkg:
  - status encodings (Waiting/Executing/Done/Fault)
  - register offset constants
  - GLOBAL_CH=4'hF
  - push FSM state enum
- Sub-module dmac_channel: one channel's register set, channel FSM, push FSM and interrupt bits.
- Top: instantiates N_CH dmac_channel copies with a generate loop, and contains the address decode, read mux and interrupt OR.

Test Plan:
- Reset, then read every register of channel 0 and 0xF0 -> all 0; s_dout updates 1 cycle after each read.
- Ch1:
  - Write SRC=0x100, DEST=0x200, SIZE=0x10, then DESCRIPTOR_PUSH=1 with fifo_full=0 -> push[1] high exactly 1 cycle, push_data = {0x10, 0x200, 0x100}.
  - Rewrite SRC=0x999 before wr_ack -> push_data unchanged.
  - wr_ack -> DESCRIPTOR_PUSH reads 0.
- Ch0 start with fifo_empty=0, INTERRUPT_ENABLE=1:
  - m_begin[0]=1 and status=01.
  - Then m_end pulse -> m_begin=0, status=10, s_interrupt=1.
  - W1C INTERRUPT=1 -> s_interrupt=0.
- Start with fifo_empty=1 -> status=11, INTERRUPT=0x2, m_begin=0; write INTERRUPT=0x2 -> status=00.
- Same cycle: m_end[0] and W1C of INTERRUPT bit0 -> bit0 remains 1. Separately, m_end[0] and m_end[1] together -> both channels Done.
- Assert reset_n=0 mid-Executing and mid-Pending -> m_begin, push and s_interrupt go to 0 immediately; writes to channel 5 (N_CH=2) are ignored and read back as 0.
